dimm_cmd_tracker: RTL and testbench
===================================

Name: dimm_cmd_tracker

Overview:
- Parametrised successor to the DIMM shell. Decodes raw DDR4 command pins into one registered command event per cycle and tracks per-bank state across all ranks, bank groups and banks.
- Flags protocol violations, such as RD to a closed bank, ACT to an open bank, or a timing window not yet met.
- Sits between the DIMM pin interface and the memory timing wrapper; feeds that wrapper's command strobes and bank models.

Parameters:
- RANKS, 1, number of chip selects / ranks
- BGWIDTH, 2, bank-group address bits
- BAWIDTH, 2, bank address bits
- ADDRWIDTH, 17, width of adr bus
- TRCD, 4, cycles from ACT until RD/WR is legal
- TRP, 4, cycles from PRE until ACT is legal
- CNTWIDTH, 4, timing counter width; must hold max(TRCD,TRP)

Ports:
- clk  in  1  command clock
- rst  in  1  asynchronous, active-high reset
- cke  in  1  clock enable
- cs_n  in  RANKS  chip selects, active low
- act_n  in  1  activate, active low
- adr  in  ADDRWIDTH  row/column/command bits; adr[16:14] = RAS_n/CAS_n/WE_n, adr[10] = AP/all
- ba  in  BAWIDTH  bank address
- bg  in  BGWIDTH  bank-group address
- par  in  1  command/address parity (used only with the feature)
- cmd_valid  out  1  one-cycle pulse: decoded command
- cmd_code  out  4  NOP=0 ACT=1 RD=2 RDA=3 WR=4 WRA=5 PR=6 PRA=7 REF=8 MRS=9 ZQC=10 PD=11 PDX=12 SRF=13 SRX=14
- cmd_rank  out  clog2(RANKS) max 1  target rank
- cmd_bank  out  BGWIDTH+BAWIDTH  {bg,ba} of target
- cmd_addr  out  ADDRWIDTH  row (ACT) or column (RD/WR)
- bank_state  out  2*NBANKS  per-bank state, NBANKS = RANKS<<(BGWIDTH+BAWIDTH), index = rank*banks_per_rank + {bg,ba}
- illegal  out  1  one-cycle pulse: protocol violation
- pwr_state  out  2  0 = ACTIVE, 1 = POWERDOWN, 2 = SELFREF
- parity_err  out  1  feature only; tied 0 otherwise

Behaviour:
- All outputs are registered. Decode latency is 1 cycle: pins sampled at edge N, event visible after edge N.
- Reset values: all outputs 0, all banks IDLE, all counters 0, pwr_state ACTIVE.
- Rank selection:
  - Selected when exactly one cs_n bit is low and cke is high.
  - All cs_n high gives NOP: cmd_valid = 0.
  - Multiple cs_n low gives illegal = 1, with no command and no state change.
- Decode when act_n = 0: ACT, with cmd_addr = adr.
- Decode when act_n = 1, on {RAS_n, CAS_n, WE_n}:
  - LLL = MRS
  - LLH = REF
  - LHL = PR, or PRA if adr[10] = 1
  - HLH = RD, or RDA if adr[10] = 1
  - HLL = WR, or WRA if adr[10] = 1
  - HHL = ZQC
  - HHH = NOP, with no pulse
  - LHH = reserved, gives illegal
- Per-bank FSM, 2-bit encoding:
  - IDLE(0) -> ACT -> OPENING(1), counter loaded with TRCD-1. Counter 0 gives ACTIVE(2).
  - ACTIVE -> PR, RDA or WRA -> CLOSING(3), counter loaded with TRP-1. Counter 0 gives IDLE.
  - PRA moves every non-IDLE bank of the rank to CLOSING.
  - PR or PRA to an IDLE bank is legal and does nothing.
- Illegal cases: the command is still reported, illegal = 1, and bank state is unchanged.
  - ACT to a non-IDLE bank.
  - RD or WR to a bank not ACTIVE, including OPENING.
  - REF or MRS while any bank of the rank is not IDLE.
- Power state on the cke falling edge (cke_q = 1, cke = 0):
  - REF decoded on that same cycle gives SRF and pwr_state SELFREF.
  - Otherwise gives PD and pwr_state POWERDOWN.
- Power state on the cke rising edge: PDX or SRX, then ACTIVE.
- While cke is low, pins are ignored, except that counters keep running.
- Simultaneous events: a counter expiry and a new command to the same bank in the same cycle are evaluated against the pre-expiry state. Example: RD on the final OPENING cycle is illegal.
- Asynchronous reset mid-operation clears all banks immediately.

Optional Feature:
- Macro: DIMM_PARITY_CHECK_EN.
- With it: expected parity is even parity over {act_n, adr, ba, bg}. When the rank is selected and par mismatches, parity_err = 1 for one cycle, the command is dropped (cmd_valid = 0) and there is no state change.
- Without it: par is unused and parity_err is constant 0.

Decomposition:
- Package dimm_pkg holds:
  - cmd_code enum
  - bank-state encoding
  - pwr_state encoding
  - RAS/CAS/WE bit positions and AP bit index (10)
- Sub-module dimm_bank_fsm: one instance per bank via generate, containing the state and timing counter. Inputs are act/pre/rd_ap/wr_ap strobes; outputs are the state.

Test Plan:
- Reset, then ACT rank0 bg=1 ba=2 adr=0x1234 -> next cycle: cmd_code=1, cmd_bank=6, cmd_addr=0x1234; bank6 OPENING for 4 cycles, then ACTIVE.
- ACT, then RD 2 cycles later -> illegal=1. RD after 4 cycles -> cmd_code=2, illegal=0.
- Open banks 0 and 5, then PRA (adr[10]=1, LHL) -> both CLOSING; both IDLE after TRP=4; REF is then legal.
- REF while bank 3 ACTIVE -> cmd_code=8, illegal=1, bank 3 stays ACTIVE.
- REF with cke falling -> cmd_code=13, pwr_state=2; cke rise -> cmd_code=14, pwr_state=0.
- With DIMM_PARITY_CHECK_EN: ACT with wrong par -> parity_err=1, cmd_valid=0, bank stays IDLE. Two cs_n low -> illegal=1.

Source files
------------

// File: rtl/dimm_pkg.sv
// Shared encodings for the DDR4 command tracker: command codes, bank and power states, pin positions.
package dimm_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ACT = 4'd1,
    CMD_RD  = 4'd2,
    CMD_RDA = 4'd3,
    CMD_WR  = 4'd4,
    CMD_WRA = 4'd5,
    CMD_PR  = 4'd6,
    CMD_PRA = 4'd7,
    CMD_REF = 4'd8,
    CMD_MRS = 4'd9,
    CMD_ZQC = 4'd10,
    CMD_PD  = 4'd11,
    CMD_PDX = 4'd12,
    CMD_SRF = 4'd13,
    CMD_SRX = 4'd14
  } cmd_code_e;

  typedef enum logic [1:0] {
    BANK_IDLE    = 2'd0,
    BANK_OPENING = 2'd1,
    BANK_ACTIVE  = 2'd2,
    BANK_CLOSING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    PWR_ACTIVE    = 2'd0,
    PWR_POWERDOWN = 2'd1,
    PWR_SELFREF   = 2'd2
  } pwr_state_e;

  localparam int unsigned RAS_BIT = 16;
  localparam int unsigned CAS_BIT = 15;
  localparam int unsigned WE_BIT  = 14;
  localparam int unsigned AP_BIT  = 10;

  // {RAS_n, CAS_n, WE_n} patterns seen with act_n high
  localparam logic [2:0] RCW_MRS  = 3'b000;
  localparam logic [2:0] RCW_REF  = 3'b001;
  localparam logic [2:0] RCW_PR   = 3'b010;
  localparam logic [2:0] RCW_RSVD = 3'b011;
  localparam logic [2:0] RCW_WR   = 3'b100;
  localparam logic [2:0] RCW_RD   = 3'b101;
  localparam logic [2:0] RCW_ZQC  = 3'b110;

endpackage

// File: rtl/dimm_bank_fsm.sv
// Single-bank open/close state machine with its tRCD/tRP countdown.
module dimm_bank_fsm
  import dimm_pkg::*;
#(
  parameter int unsigned CNTWIDTH = 4,
  parameter int unsigned TRCD     = 4,
  parameter int unsigned TRP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_act,
  input  logic       i_pre,
  input  logic       i_rd_ap,
  input  logic       i_wr_ap,
  output logic [1:0] o_state
);

  localparam logic [CNTWIDTH-1:0] TRCD_LD = CNTWIDTH'(TRCD - 1);
  localparam logic [CNTWIDTH-1:0] TRP_LD  = CNTWIDTH'(TRP - 1);

  bank_state_e         r_state;
  bank_state_e         w_state_nxt;
  logic [CNTWIDTH-1:0] r_cnt;
  logic [CNTWIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BANK_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Expiry is judged on the current count, so a strobe in the last timed cycle sees the old state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      BANK_IDLE: begin
        if (i_act) begin
          w_state_nxt = BANK_OPENING;
          w_cnt_nxt   = TRCD_LD;
        end
      end
      BANK_OPENING: begin
        if (i_pre) begin
          w_state_nxt = BANK_CLOSING;
          w_cnt_nxt   = TRP_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = BANK_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - CNTWIDTH'(1);
        end
      end
      BANK_ACTIVE: begin
        if (i_pre || i_rd_ap || i_wr_ap) begin
          w_state_nxt = BANK_CLOSING;
          w_cnt_nxt   = TRP_LD;
        end
      end
      BANK_CLOSING: begin
        if (r_cnt == '0) begin
          w_state_nxt = BANK_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNTWIDTH'(1);
        end
      end
      default: w_state_nxt = BANK_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/dimm_cmd_tracker.sv
// DDR4 pin decoder and per-bank state tracker across ranks, bank groups and banks.
// Optional CA parity checking is enabled by defining DIMM_PARITY_CHECK_EN.
module dimm_cmd_tracker
  import dimm_pkg::*;
#(
  parameter int unsigned RANKS     = 1,
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned TRCD      = 4,
  parameter int unsigned TRP       = 4,
  parameter int unsigned CNTWIDTH  = 4,
  localparam int unsigned RW       = (RANKS > 1) ? $clog2(RANKS) : 1,
  localparam int unsigned BKW      = BGWIDTH + BAWIDTH,
  localparam int unsigned NBANKS   = RANKS << BKW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic [RANKS-1:0]     cs_n,
  input  logic                 act_n,
  input  logic [ADDRWIDTH-1:0] adr,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic                 par,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_code,
  output logic [RW-1:0]        cmd_rank,
  output logic [BKW-1:0]       cmd_bank,
  output logic [ADDRWIDTH-1:0] cmd_addr,
  output logic [2*NBANKS-1:0]  bank_state,
  output logic                 illegal,
  output logic [1:0]           pwr_state,
  output logic                 parity_err
);

  localparam int unsigned BPR   = 1 << BKW;
  localparam int unsigned BIDXW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic                 r_cke_q;
  logic                 r_cmd_valid;
  cmd_code_e            r_cmd_code;
  logic [RW-1:0]        r_cmd_rank;
  logic [BKW-1:0]       r_cmd_bank;
  logic [ADDRWIDTH-1:0] r_cmd_addr;
  logic                 r_illegal;
  logic                 r_parity_err;
  pwr_state_e           r_pwr_state;

  logic [1:0]           w_state [NBANKS];
  logic [NBANKS-1:0]    w_act;
  logic [NBANKS-1:0]    w_pre;
  logic [NBANKS-1:0]    w_rd_ap;
  logic [NBANKS-1:0]    w_wr_ap;
  logic [RANKS-1:0]     w_rank_busy;
  logic [RW-1:0]        w_rank;
  logic [BIDXW-1:0]     w_bidx;
  logic [1:0]           w_cur;
  logic                 w_none_sel;
  logic                 w_one_sel;
  logic                 w_par_bad;
  logic [2:0]           w_rcw;
  logic                 w_ap;
  logic                 w_valid;
  cmd_code_e            w_code;
  logic                 w_illegal;
  logic                 w_perr;
  pwr_state_e           w_pwr_nxt;

`ifdef DIMM_PARITY_CHECK_EN
  assign w_par_bad = (par != ^{act_n, adr, ba, bg});
`else
  logic w_unused_par;
  assign w_unused_par = par;
  assign w_par_bad    = 1'b0;
`endif

  assign w_none_sel = &cs_n;
  assign w_one_sel  = $onehot(~cs_n);
  assign w_bidx     = BIDXW'({w_rank, bg, ba});
  assign w_cur      = w_state[w_bidx];
  assign w_rcw      = {adr[RAS_BIT], adr[CAS_BIT], adr[WE_BIT]};
  assign w_ap       = adr[AP_BIT];

  always_comb begin
    w_rank = '0;
    for (int r = 0; r < int'(RANKS); r++) begin
      if (!cs_n[r]) w_rank = RW'(r);
    end
  end

  always_comb begin
    w_rank_busy = '0;
    for (int b = 0; b < int'(NBANKS); b++) begin
      if (w_state[b] != BANK_IDLE) w_rank_busy[b / int'(BPR)] = 1'b1;
    end
  end

  // Command decode, legality check and per-bank strobe generation
  always_comb begin
    w_valid   = 1'b0;
    w_code    = CMD_NOP;
    w_illegal = 1'b0;
    w_perr    = 1'b0;
    w_pwr_nxt = r_pwr_state;
    w_act     = '0;
    w_pre     = '0;
    w_rd_ap   = '0;
    w_wr_ap   = '0;
    if (r_cke_q && !cke) begin
      w_valid = 1'b1;
      if (w_one_sel && act_n && (w_rcw == RCW_REF)) begin
        w_code    = CMD_SRF;
        w_pwr_nxt = PWR_SELFREF;
      end else begin
        w_code    = CMD_PD;
        w_pwr_nxt = PWR_POWERDOWN;
      end
    end else if (!r_cke_q && cke) begin
      w_valid   = 1'b1;
      w_code    = (r_pwr_state == PWR_SELFREF) ? CMD_SRX : CMD_PDX;
      w_pwr_nxt = PWR_ACTIVE;
    end else if (cke) begin
      if (!w_none_sel && !w_one_sel) begin
        w_illegal = 1'b1;
      end else if (w_one_sel && w_par_bad) begin
        w_perr = 1'b1;
      end else if (w_one_sel && !act_n) begin
        w_valid = 1'b1;
        w_code  = CMD_ACT;
        if (w_cur != BANK_IDLE) w_illegal = 1'b1;
        else                    w_act[w_bidx] = 1'b1;
      end else if (w_one_sel) begin
        case (w_rcw)
          RCW_MRS, RCW_REF: begin
            w_valid   = 1'b1;
            w_code    = (w_rcw == RCW_MRS) ? CMD_MRS : CMD_REF;
            w_illegal = w_rank_busy[w_rank];
          end
          RCW_PR: begin
            w_valid = 1'b1;
            if (w_ap) begin
              w_code = CMD_PRA;
              for (int b = 0; b < int'(NBANKS); b++) begin
                if ((b / int'(BPR)) == int'(w_rank) &&
                    (w_state[b] == BANK_OPENING || w_state[b] == BANK_ACTIVE))
                  w_pre[b] = 1'b1;
              end
            end else begin
              w_code = CMD_PR;
              if (w_cur == BANK_ACTIVE) w_pre[w_bidx] = 1'b1;
            end
          end
          RCW_RD, RCW_WR: begin
            w_valid = 1'b1;
            if (w_rcw == RCW_RD) w_code = w_ap ? CMD_RDA : CMD_RD;
            else                 w_code = w_ap ? CMD_WRA : CMD_WR;
            if (w_cur != BANK_ACTIVE) begin
              w_illegal = 1'b1;
            end else if (w_ap) begin
              if (w_rcw == RCW_RD) w_rd_ap[w_bidx] = 1'b1;
              else                 w_wr_ap[w_bidx] = 1'b1;
            end
          end
          RCW_ZQC: begin
            w_valid = 1'b1;
            w_code  = CMD_ZQC;
          end
          RCW_RSVD: w_illegal = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cke_q      <= 1'b1;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= CMD_NOP;
      r_cmd_rank   <= '0;
      r_cmd_bank   <= '0;
      r_cmd_addr   <= '0;
      r_illegal    <= 1'b0;
      r_parity_err <= 1'b0;
      r_pwr_state  <= PWR_ACTIVE;
    end else begin
      r_cke_q      <= cke;
      r_cmd_valid  <= w_valid;
      r_cmd_code   <= w_code;
      r_cmd_rank   <= w_rank;
      r_cmd_bank   <= {bg, ba};
      r_cmd_addr   <= adr;
      r_illegal    <= w_illegal;
      r_parity_err <= w_perr;
      r_pwr_state  <= w_pwr_nxt;
    end
  end

  for (genvar i = 0; i < int'(NBANKS); i++) begin : g_bank
    dimm_bank_fsm #(
      .CNTWIDTH (CNTWIDTH),
      .TRCD     (TRCD),
      .TRP      (TRP)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_act   (w_act[i]),
      .i_pre   (w_pre[i]),
      .i_rd_ap (w_rd_ap[i]),
      .i_wr_ap (w_wr_ap[i]),
      .o_state (w_state[i])
    );
    assign bank_state[2*i +: 2] = w_state[i];
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign cmd_rank   = r_cmd_rank;
  assign cmd_bank   = r_cmd_bank;
  assign cmd_addr   = r_cmd_addr;
  assign illegal    = r_illegal;
  assign pwr_state  = r_pwr_state;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_dimm_cmd_tracker.sv
// Directed bench for dimm_cmd_tracker with two ranks; parity scenario runs when DIMM_PARITY_CHECK_EN is defined.
module tb_dimm_cmd_tracker;

  localparam logic [1:0] R0 = 2'b10;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] NONE = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic [1:0]  cs_n;
  logic        act_n;
  logic [16:0] adr;
  logic [1:0]  ba;
  logic [1:0]  bg;
  logic        par;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [0:0]  cmd_rank;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_addr;
  logic [63:0] bank_state;
  logic        illegal;
  logic [1:0]  pwr_state;
  logic        parity_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] ev;

  always #5 clk = ~clk;

  dimm_cmd_tracker #(.RANKS(2)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n), .adr(adr),
    .ba(ba), .bg(bg), .par(par), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_rank(cmd_rank), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
    .bank_state(bank_state), .illegal(illegal), .pwr_state(pwr_state),
    .parity_err(parity_err)
  );

  function automatic logic [1:0] bst(input int i);
    return bank_state[2*i +: 2];
  endfunction

  function automatic logic [16:0] mk(input logic [2:0] rcw, input logic ap);
    return {rcw, 3'b000, ap, 10'h000};
  endfunction

  task automatic pins(input logic [1:0] cs, input logic an, input logic [16:0] a,
                      input logic [1:0] g, input logic [1:0] b);
    cs_n = cs; act_n = an; adr = a; bg = g; ba = b;
    par = ^{an, a, b, g};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pins(NONE, 1'b1, mk(3'b111, 1'b0), 2'd0, 2'd0);
    repeat (n) tick();
  endtask

  task automatic act(input logic [1:0] cs, input logic [1:0] g, input logic [1:0] b,
                     input logic [16:0] row);
    pins(cs, 1'b0, row, g, b);
    tick();
  endtask

  task automatic cmd(input logic [1:0] cs, input logic [2:0] rcw, input logic ap,
                     input logic [1:0] g, input logic [1:0] b);
    pins(cs, 1'b1, mk(rcw, ap), g, b);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cke = 1'b1;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, parity_err, pwr_state} !== 9'h0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h want 000", {cmd_valid, cmd_code, illegal, parity_err, pwr_state});
    end
    n_checks++;
    if (bank_state !== 64'h0) begin
      n_errors++; $display("FAIL reset_banks got %h want 0", bank_state);
    end
    rst = 1'b0;
    idle(2);
    n_checks++;
    if ({cmd_valid, illegal, pwr_state, bank_state} !== 68'h0) begin
      n_errors++; $display("FAIL post_reset_idle got %h want 0", {cmd_valid, illegal, pwr_state, bank_state});
    end
  endtask

  task automatic test_act_timing();
    act(R0, 2'd1, 2'd2, 17'h01234);
    ev = {cmd_valid, cmd_code, illegal};
    n_checks++;
    if (ev !== {1'b1, 4'd1, 1'b0}) begin
      n_errors++; $display("FAIL act_event got %h want %h", ev, {1'b1, 4'd1, 1'b0});
    end
    n_checks++;
    if ({cmd_rank, cmd_bank, cmd_addr, bst(6)} !== {1'b0, 4'd6, 17'h01234, 2'd1}) begin
      n_errors++; $display("FAIL act_fields got %h want %h", {cmd_rank, cmd_bank, cmd_addr, bst(6)},
                           {1'b0, 4'd6, 17'h01234, 2'd1});
    end
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      n_checks++;
      if (bst(6) !== ((k < 4) ? 2'd1 : 2'd2)) begin
        n_errors++; $display("FAIL act_open_cycle%0d got %0d want %0d", k, bst(6), (k < 4) ? 1 : 2);
      end
    end
    cmd(R0, 3'b010, 1'b0, 2'd1, 2'd2);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(6)} !== {1'b1, 4'd6, 1'b0, 2'd3}) begin
      n_errors++; $display("FAIL pr_close got %h want %h", {cmd_valid, cmd_code, illegal, bst(6)}, {1'b1, 4'd6, 1'b0, 2'd3});
    end
    idle(4);
    n_checks++;
    if (bst(6) !== 2'd0) begin
      n_errors++; $display("FAIL pr_idle got %0d want 0", bst(6));
    end
  endtask

  task automatic test_rd_window();
    act(R0, 2'd0, 2'd0, 17'h00055);
    idle(1);
    cmd(R0, 3'b101, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(0)} !== {1'b1, 4'd2, 1'b1, 2'd1}) begin
      n_errors++; $display("FAIL rd_early got %h want %h", {cmd_valid, cmd_code, illegal, bst(0)}, {1'b1, 4'd2, 1'b1, 2'd1});
    end
    idle(1);
    cmd(R0, 3'b101, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(0)} !== {1'b1, 4'd2, 1'b1, 2'd2}) begin
      n_errors++; $display("FAIL rd_last_opening got %h want %h", {cmd_valid, cmd_code, illegal, bst(0)}, {1'b1, 4'd2, 1'b1, 2'd2});
    end
    cmd(R0, 3'b101, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(0)} !== {1'b1, 4'd2, 1'b0, 2'd2}) begin
      n_errors++; $display("FAIL rd_legal got %h want %h", {cmd_valid, cmd_code, illegal, bst(0)}, {1'b1, 4'd2, 1'b0, 2'd2});
    end
    cmd(R0, 3'b101, 1'b1, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(0)} !== {1'b1, 4'd3, 1'b0, 2'd3}) begin
      n_errors++; $display("FAIL rda_close got %h want %h", {cmd_valid, cmd_code, illegal, bst(0)}, {1'b1, 4'd3, 1'b0, 2'd3});
    end
    idle(3);
    n_checks++;
    if (bst(0) !== 2'd3) begin
      n_errors++; $display("FAIL rda_last_closing got %0d want 3", bst(0));
    end
    idle(1);
    n_checks++;
    if (bst(0) !== 2'd0) begin
      n_errors++; $display("FAIL rda_idle got %0d want 0", bst(0));
    end
  endtask

  task automatic test_pra();
    act(R0, 2'd0, 2'd0, 17'h00AAA);
    act(R0, 2'd1, 2'd1, 17'h00BBB);
    act(R1, 2'd0, 2'd0, 17'h00CCC);
    idle(5);
    n_checks++;
    if ({bst(0), bst(5), bst(16)} !== {2'd2, 2'd2, 2'd2}) begin
      n_errors++; $display("FAIL pra_open got %h want 2a", {bst(0), bst(5), bst(16)});
    end
    cmd(R0, 3'b010, 1'b1, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(0), bst(5), bst(16)} !== {1'b1, 4'd7, 1'b0, 2'd3, 2'd3, 2'd2}) begin
      n_errors++; $display("FAIL pra_closing got %h want %h", {cmd_valid, cmd_code, illegal, bst(0), bst(5), bst(16)},
                           {1'b1, 4'd7, 1'b0, 2'd3, 2'd3, 2'd2});
    end
    idle(3);
    n_checks++;
    if ({bst(0), bst(5)} !== {2'd3, 2'd3}) begin
      n_errors++; $display("FAIL pra_still_closing got %h want f", {bst(0), bst(5)});
    end
    idle(1);
    n_checks++;
    if ({bst(0), bst(5)} !== 4'h0) begin
      n_errors++; $display("FAIL pra_idle got %h want 0", {bst(0), bst(5)});
    end
    cmd(R0, 3'b001, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal} !== {1'b1, 4'd8, 1'b0}) begin
      n_errors++; $display("FAIL ref_after_pra got %h want %h", {cmd_valid, cmd_code, illegal}, {1'b1, 4'd8, 1'b0});
    end
    cmd(R1, 3'b001, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, cmd_rank} !== {1'b1, 4'd8, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL ref_rank1_busy got %h want %h", {cmd_valid, cmd_code, illegal, cmd_rank}, {1'b1, 4'd8, 1'b1, 1'b1});
    end
    cmd(R1, 3'b010, 1'b0, 2'd0, 2'd0);
    idle(4);
    n_checks++;
    if (bst(16) !== 2'd0) begin
      n_errors++; $display("FAIL rank1_idle got %0d want 0", bst(16));
    end
  endtask

  task automatic test_ref_busy();
    act(R0, 2'd0, 2'd3, 17'h00777);
    idle(4);
    n_checks++;
    if (bst(3) !== 2'd2) begin
      n_errors++; $display("FAIL b3_active got %0d want 2", bst(3));
    end
    cmd(R0, 3'b001, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(3)} !== {1'b1, 4'd8, 1'b1, 2'd2}) begin
      n_errors++; $display("FAIL ref_busy got %h want %h", {cmd_valid, cmd_code, illegal, bst(3)}, {1'b1, 4'd8, 1'b1, 2'd2});
    end
    cmd(R0, 3'b000, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal} !== {1'b1, 4'd9, 1'b1}) begin
      n_errors++; $display("FAIL mrs_busy got %h want %h", {cmd_valid, cmd_code, illegal}, {1'b1, 4'd9, 1'b1});
    end
    act(R0, 2'd0, 2'd3, 17'h00111);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(3)} !== {1'b1, 4'd1, 1'b1, 2'd2}) begin
      n_errors++; $display("FAIL act_open_bank got %h want %h", {cmd_valid, cmd_code, illegal, bst(3)}, {1'b1, 4'd1, 1'b1, 2'd2});
    end
    cmd(R0, 3'b100, 1'b0, 2'd0, 2'd3);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(3)} !== {1'b1, 4'd4, 1'b0, 2'd2}) begin
      n_errors++; $display("FAIL wr_legal got %h want %h", {cmd_valid, cmd_code, illegal, bst(3)}, {1'b1, 4'd4, 1'b0, 2'd2});
    end
    cmd(R0, 3'b010, 1'b0, 2'd0, 2'd2);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal, bst(2)} !== {1'b1, 4'd6, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL pr_idle_bank got %h want %h", {cmd_valid, cmd_code, illegal, bst(2)}, {1'b1, 4'd6, 1'b0, 2'd0});
    end
    cmd(R0, 3'b110, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, illegal} !== {1'b1, 4'd10, 1'b0}) begin
      n_errors++; $display("FAIL zqc got %h want %h", {cmd_valid, cmd_code, illegal}, {1'b1, 4'd10, 1'b0});
    end
    cmd(R0, 3'b010, 1'b0, 2'd0, 2'd3);
    idle(4);
    n_checks++;
    if (bst(3) !== 2'd0) begin
      n_errors++; $display("FAIL b3_idle got %0d want 0", bst(3));
    end
  endtask

  task automatic test_bad_pins();
    act(2'b00, 2'd0, 2'd0, 17'h00001);
    n_checks++;
    if ({cmd_valid, illegal, bst(0)} !== {1'b0, 1'b1, 2'd0}) begin
      n_errors++; $display("FAIL multi_cs got %h want %h", {cmd_valid, illegal, bst(0)}, {1'b0, 1'b1, 2'd0});
    end
    cmd(R0, 3'b011, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, illegal} !== 2'b01) begin
      n_errors++; $display("FAIL reserved got %b want 01", {cmd_valid, illegal});
    end
    cmd(R0, 3'b111, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, illegal} !== 2'b00) begin
      n_errors++; $display("FAIL nop_selected got %b want 00", {cmd_valid, illegal});
    end
    idle(1);
  endtask

  task automatic test_power();
    cke = 1'b0;
    cmd(R0, 3'b001, 1'b0, 2'd0, 2'd0);
    n_checks++;
    if ({cmd_valid, cmd_code, pwr_state} !== {1'b1, 4'd13, 2'd2}) begin
      n_errors++; $display("FAIL srf got %h want %h", {cmd_valid, cmd_code, pwr_state}, {1'b1, 4'd13, 2'd2});
    end
    act(R0, 2'd0, 2'd0, 17'h00002);
    n_checks++;
    if ({cmd_valid, illegal, pwr_state, bst(0)} !== {1'b0, 1'b0, 2'd2, 2'd0}) begin
      n_errors++; $display("FAIL sr_ignore got %h want %h", {cmd_valid, illegal, pwr_state, bst(0)}, {1'b0, 1'b0, 2'd2, 2'd0});
    end
    cke = 1'b1;
    idle(1);
    n_checks++;
    if ({cmd_valid, cmd_code, pwr_state} !== {1'b1, 4'd14, 2'd0}) begin
      n_errors++; $display("FAIL srx got %h want %h", {cmd_valid, cmd_code, pwr_state}, {1'b1, 4'd14, 2'd0});
    end
    act(R0, 2'd0, 2'd1, 17'h00003);
    cke = 1'b0;
    idle(1);
    n_checks++;
    if ({cmd_valid, cmd_code, pwr_state} !== {1'b1, 4'd11, 2'd1}) begin
      n_errors++; $display("FAIL pd got %h want %h", {cmd_valid, cmd_code, pwr_state}, {1'b1, 4'd11, 2'd1});
    end
    idle(3);
    n_checks++;
    if ({bst(1), pwr_state} !== {2'd2, 2'd1}) begin
      n_errors++; $display("FAIL pd_counter_runs got %h want 9", {bst(1), pwr_state});
    end
    cke = 1'b1;
    idle(1);
    n_checks++;
    if ({cmd_valid, cmd_code, pwr_state} !== {1'b1, 4'd12, 2'd0}) begin
      n_errors++; $display("FAIL pdx got %h want %h", {cmd_valid, cmd_code, pwr_state}, {1'b1, 4'd12, 2'd0});
    end
    cmd(R0, 3'b010, 1'b0, 2'd0, 2'd1);
    idle(4);
  endtask

`ifdef DIMM_PARITY_CHECK_EN
  task automatic test_parity();
    pins(R0, 1'b0, 17'h00004, 2'd0, 2'd0);
    par = ~par;
    tick();
    n_checks++;
    if ({parity_err, cmd_valid, bst(0)} !== {1'b1, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL parity_drop got %h want %h", {parity_err, cmd_valid, bst(0)}, {1'b1, 1'b0, 2'd0});
    end
    idle(1);
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_errors++; $display("FAIL parity_pulse got %b want 0", parity_err);
    end
  endtask
`endif

  task automatic test_async_reset();
    act(R0, 2'd1, 2'd3, 17'h00009);
    n_checks++;
    if (bst(7) !== 2'd1) begin
      n_errors++; $display("FAIL pre_reset_open got %0d want 1", bst(7));
    end
    rst = 1'b1;
    #2;
    n_checks++;
    if ({bank_state, cmd_valid} !== 65'h0) begin
      n_errors++; $display("FAIL async_reset got %h want 0", {bank_state, cmd_valid});
    end
    idle(1);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_act_timing();
    test_rd_window();
    test_pra();
    test_ref_busy();
    test_bad_pins();
    test_power();
`ifdef DIMM_PARITY_CHECK_EN
    test_parity();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
